// File: rtl/display_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment scanner.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package display_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // Entry [n] is the pattern for hex digit n (leftmost element is index 15).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/module_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module module_hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/module_display_scan.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous value update.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1.
module module_display_scan
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 27000,
    parameter int BLANK_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    output logic        pending,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int             CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CYC);

    logic [CW-1:0] r_cnt;
    digit_idx_t    r_idx;
    logic [15:0]   r_shadow;
    logic [15:0]   r_disp;
    logic          r_pending;
    logic          r_frame_done;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    logic          w_tc;
    logic          w_fb;
    logic          w_blank;
    logic          w_lz;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg_dec;

    assign w_tc    = (r_cnt == CNT_LAST);
    assign w_fb    = w_tc && (r_idx == 2'd3);
    assign w_blank = (r_cnt < CNT_BLANK);
    assign w_nib   = 4'(r_disp >> {r_idx, 2'b00});

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more-significant digit are zero.
    always_comb begin
        w_lz = 1'b0;
        case (r_idx)
            2'd3:    w_lz = (r_disp[15:12] == 4'h0);
            2'd2:    w_lz = (r_disp[15:8]  == 8'h00);
            2'd1:    w_lz = (r_disp[15:4]  == 12'h000);
            default: w_lz = 1'b0;
        endcase
    end
`else
    assign w_lz = 1'b0;
`endif

    module_hex_to_seg u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg_dec)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_tc) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Display only changes at the frame boundary so a frame never tears.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shadow     <= 16'h0000;
            r_disp       <= 16'h0000;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_fb;
            if (w_fb && load) begin
                r_shadow  <= value;
                r_disp    <= value;
                r_pending <= 1'b0;
            end else if (w_fb) begin
                r_disp    <= r_shadow;
                r_pending <= 1'b0;
            end else if (load) begin
                r_shadow  <= value;
                r_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
        end else if (w_blank) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
        end else begin
            r_an  <= AN_OFF ^ (4'b0001 << r_idx);
            r_seg <= w_lz ? SEG_OFF : w_seg_dec;
        end
    end

    assign pending    = r_pending;
    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule
